// File: rtl/oflow_calc_iou.sv
// oflow_calc_iou -- intersection-over-union of two axis-aligned boxes.
//
// A sequential engine that captures a current box and a history box, computes
// the overlap area and the union area, and divides them with a restoring
// divider, producing an unsigned q0.IOU_LEN ratio.
//
// Ports:
//   clk                          in   clock, all state on rising edge
//   reset_N                      in   asynchronous active-low reset
//   start                        in   request a computation (sampled in IDLE only)
//   bbox_position_frame_k        in   {X_TL, Y_TL, X_BR, Y_BR} of current box
//   bbox_position_frame_history  in   same packing, history box
//   bbox_w/h_frame_k             in   current box width / height
//   bbox_w/h_frame_history       in   history box width / height
//   valid_iou                    out  one-cycle pulse, iou holds a new result
//   iou                          out  IOU result, q0.IOU_LEN, held between results
//
// Latency: start sampled in cycle 0 -> valid_iou in cycle 25
// (INTER, AREA, IOU_LEN divide cycles, DONE).
//
// Build option: define OFLOW_IOU_EARLY_ZERO_EN to bypass the divider when the
// intersection is empty (result 0, valid_iou in cycle 3).

module oflow_calc_iou #(
  parameter int COORD_LEN = 11,
  parameter int WH_LEN    = 8,
  parameter int IOU_LEN   = 22
) (
  input  logic                   clk,
  input  logic                   reset_N,
  input  logic                   start,
  input  logic [4*COORD_LEN-1:0] bbox_position_frame_k,
  input  logic [4*COORD_LEN-1:0] bbox_position_frame_history,
  input  logic [WH_LEN-1:0]      bbox_w_frame_k,
  input  logic [WH_LEN-1:0]      bbox_h_frame_k,
  input  logic [WH_LEN-1:0]      bbox_w_frame_history,
  input  logic [WH_LEN-1:0]      bbox_h_frame_history,
  output logic                   valid_iou,
  output logic [IOU_LEN-1:0]     iou
);

  // Widths: intersection product, sum of the two box areas, and a working
  // width one bit wider than either so the union difference keeps its sign.
  localparam int IN_W  = 2 * COORD_LEN;
  localparam int SUM_W = 2 * WH_LEN + 1;
  localparam int UW    = ((IN_W > SUM_W) ? IN_W : SUM_W) + 1;
  localparam int CNT_W = (IOU_LEN > 2) ? $clog2(IOU_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INTER,
    AREA,
    DIV,
    DONE
  } state_t;

  state_t state_q, state_d;

  // Captured inputs
  logic [4*COORD_LEN-1:0] box_k_q, box_h_q;
  logic [WH_LEN-1:0]      w_k_q, h_k_q, w_h_q, h_h_q;

  // Intersection extents
  logic [COORD_LEN-1:0]   iw_q, ih_q;

  // Divider state
  logic [UW-1:0]          rem_q, dvs_q;
  logic [IOU_LEN-1:0]     quot_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sat_q, zero_q;

  logic [IOU_LEN-1:0]     iou_q;

  // ---------------------------------------------------------------------------
  // INTER: overlap extents of the captured boxes
  // ---------------------------------------------------------------------------
  logic [COORD_LEN-1:0] kx1, ky1, kx2, ky2, hx1, hy1, hx2, hy2;
  logic [COORD_LEN-1:0] x_lo, x_hi, y_lo, y_hi;
  logic [COORD_LEN-1:0] iw_c, ih_c;

  always_comb begin
    kx1 = box_k_q[4*COORD_LEN-1:3*COORD_LEN];
    ky1 = box_k_q[3*COORD_LEN-1:2*COORD_LEN];
    kx2 = box_k_q[2*COORD_LEN-1:COORD_LEN];
    ky2 = box_k_q[COORD_LEN-1:0];
    hx1 = box_h_q[4*COORD_LEN-1:3*COORD_LEN];
    hy1 = box_h_q[3*COORD_LEN-1:2*COORD_LEN];
    hx2 = box_h_q[2*COORD_LEN-1:COORD_LEN];
    hy2 = box_h_q[COORD_LEN-1:0];

    x_lo = (kx1 > hx1) ? kx1 : hx1;
    x_hi = (kx2 < hx2) ? kx2 : hx2;
    y_lo = (ky1 > hy1) ? ky1 : hy1;
    y_hi = (ky2 < hy2) ? ky2 : hy2;

    // Strict compare: touching edges give an empty overlap.
    iw_c = (x_hi > x_lo) ? (x_hi - x_lo) : '0;
    ih_c = (y_hi > y_lo) ? (y_hi - y_lo) : '0;
  end

  // ---------------------------------------------------------------------------
  // AREA: intersection, union and the divide/saturate decision
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0]  inter_c;
  logic [SUM_W-1:0] area_k_c, area_h_c, sum_c;
  logic [UW-1:0]    inter_ext, sum_ext, union_c;
  logic             union_neg, union_zero, union_sat;

  always_comb begin
    inter_c    = IN_W'(iw_q) * IN_W'(ih_q);
    area_k_c   = SUM_W'(w_k_q) * SUM_W'(h_k_q);
    area_h_c   = SUM_W'(w_h_q) * SUM_W'(h_h_q);
    sum_c      = area_k_c + area_h_c;
    inter_ext  = UW'(inter_c);
    sum_ext    = UW'(sum_c);
    // Both operands are below 2^(UW-1), so the MSB of the difference is its
    // sign; inconsistent w/h inputs may make the union negative.
    union_c    = sum_ext - inter_ext;
    union_neg  = union_c[UW-1];
    union_zero = (union_c == '0);
    union_sat  = !union_zero && (union_neg || (inter_ext >= union_c));
  end

  // ---------------------------------------------------------------------------
  // DIV: one restoring step per cycle. The dividend is below the divisor when
  // the result is actually used, so the doubled remainder always fits in UW.
  // ---------------------------------------------------------------------------
  logic [UW-1:0]      rem_sh, rem_nx;
  logic               q_bit;
  logic [IOU_LEN-1:0] quot_nx;
  logic [IOU_LEN-1:0] result_c;
  logic               div_last;

  always_comb begin
    rem_sh   = {rem_q[UW-2:0], 1'b0};
    q_bit    = (rem_sh >= dvs_q);
    rem_nx   = q_bit ? (rem_sh - dvs_q) : rem_sh;
    quot_nx  = {quot_q[IOU_LEN-2:0], q_bit};
    div_last = (cnt_q == CNT_W'(IOU_LEN - 1));
    if (sat_q) begin
      result_c = '1;
    end else if (zero_q) begin
      result_c = '0;
    end else begin
      result_c = quot_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = INTER;
      INTER: state_d = AREA;
      AREA: begin
`ifdef OFLOW_IOU_EARLY_ZERO_EN
        if (inter_c == '0) begin
          state_d = DONE;
        end else begin
          state_d = DIV;
        end
`else
        state_d = DIV;
`endif
      end
      DIV:   if (div_last) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      box_k_q <= '0;
      box_h_q <= '0;
      w_k_q   <= '0;
      h_k_q   <= '0;
      w_h_q   <= '0;
      h_h_q   <= '0;
      iw_q    <= '0;
      ih_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      zero_q  <= 1'b0;
      iou_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            box_k_q <= bbox_position_frame_k;
            box_h_q <= bbox_position_frame_history;
            w_k_q   <= bbox_w_frame_k;
            h_k_q   <= bbox_h_frame_k;
            w_h_q   <= bbox_w_frame_history;
            h_h_q   <= bbox_h_frame_history;
          end
        end
        INTER: begin
          iw_q <= iw_c;
          ih_q <= ih_c;
        end
        AREA: begin
          rem_q  <= inter_ext;
          dvs_q  <= union_c;
          quot_q <= '0;
          cnt_q  <= '0;
          sat_q  <= union_sat;
          zero_q <= union_zero;
`ifdef OFLOW_IOU_EARLY_ZERO_EN
          if (inter_c == '0) begin
            iou_q <= '0;
          end
`endif
        end
        DIV: begin
          rem_q  <= rem_nx;
          quot_q <= quot_nx;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (div_last) begin
            iou_q <= result_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_iou = (state_q == DONE);
  assign iou       = iou_q;

endmodule

// File: tb/tb_oflow_calc_iou.sv
// Testbench for oflow_calc_iou: scoreboard queue filled at stimulus time,
// monitor pops on every valid_iou and checks value and arrival cycle.

module tb_oflow_calc_iou;

  localparam int COORD_LEN = 11;
  localparam int WH_LEN    = 8;
  localparam int IOU_LEN   = 22;
`ifdef OFLOW_IOU_EARLY_ZERO_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic                   clk;
  logic                   reset_N;
  logic                   start;
  logic [4*COORD_LEN-1:0] bbox_position_frame_k;
  logic [4*COORD_LEN-1:0] bbox_position_frame_history;
  logic [WH_LEN-1:0]      bbox_w_frame_k, bbox_h_frame_k;
  logic [WH_LEN-1:0]      bbox_w_frame_history, bbox_h_frame_history;
  logic                   valid_iou;
  logic [IOU_LEN-1:0]     iou;

  oflow_calc_iou #(
    .COORD_LEN(COORD_LEN),
    .WH_LEN   (WH_LEN),
    .IOU_LEN  (IOU_LEN)
  ) dut (
    .clk                         (clk),
    .reset_N                     (reset_N),
    .start                       (start),
    .bbox_position_frame_k       (bbox_position_frame_k),
    .bbox_position_frame_history (bbox_position_frame_history),
    .bbox_w_frame_k              (bbox_w_frame_k),
    .bbox_h_frame_k              (bbox_h_frame_k),
    .bbox_w_frame_history        (bbox_w_frame_history),
    .bbox_h_frame_history        (bbox_h_frame_history),
    .valid_iou                   (valid_iou),
    .iou                         (iou)
  );

  typedef struct {
    int kx1, ky1, kx2, ky2;
    int hx1, hy1, hx2, hy2;
    int wk, hk, wh, hh;
  } box_t;

  typedef struct {
    logic [IOU_LEN-1:0] val;
    int                 cyc;
  } exp_t;

  exp_t               sbq[$];
  int                 errors = 0;
  int                 checks = 0;
  int                 cyc = 0;
  bit                 in_rst = 1'b1;
  logic [IOU_LEN-1:0] last_iou = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: overlap area over union area, as a fraction scaled by 2^22.
  function automatic longint ref_iou(input box_t b, output longint inter);
    int iw, ih;
    longint un;
    iw = ((b.kx2 < b.hx2) ? b.kx2 : b.hx2) - ((b.kx1 > b.hx1) ? b.kx1 : b.hx1);
    ih = ((b.ky2 < b.hy2) ? b.ky2 : b.hy2) - ((b.ky1 > b.hy1) ? b.ky1 : b.hy1);
    if (iw < 0) iw = 0;
    if (ih < 0) ih = 0;
    inter = longint'(iw) * longint'(ih);
    un = longint'(b.wk) * b.hk + longint'(b.wh) * b.hh - inter;
    if (un == 0) return 0;
    if (inter >= un) return (longint'(1) << IOU_LEN) - 1;
    return (inter << IOU_LEN) / un;
  endfunction

  task automatic apply(input box_t b);
    bbox_position_frame_k       = {11'(b.kx1), 11'(b.ky1), 11'(b.kx2), 11'(b.ky2)};
    bbox_position_frame_history = {11'(b.hx1), 11'(b.hy1), 11'(b.hx2), 11'(b.hy2)};
    bbox_w_frame_k              = 8'(b.wk);
    bbox_h_frame_k              = 8'(b.hk);
    bbox_w_frame_history        = 8'(b.wh);
    bbox_h_frame_history        = 8'(b.hh);
  endtask

  // Called at a negedge (cycle 0); returns at the next negedge (cycle 1).
  task automatic issue(input box_t b, output int lat);
    longint inter, r;
    exp_t   e;
    r = ref_iou(b, inter);
    lat = (EARLY && inter == 0) ? 3 : 25;
    e.val = IOU_LEN'(r);
    e.cyc = cyc + lat;
    sbq.push_back(e);
    apply(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run one transaction and return in the first IDLE cycle after DONE.
  task automatic run(input box_t b);
    int lat;
    issue(b, lat);
    repeat (lat) @(negedge clk);
  endtask

  function automatic box_t mk(input int a1, a2, a3, a4, b1, b2, b3, b4,
                              input int wk, hk, wh, hh);
    box_t b;
    b.kx1 = a1; b.ky1 = a2; b.kx2 = a3; b.ky2 = a4;
    b.hx1 = b1; b.hy1 = b2; b.hx2 = b3; b.hy2 = b4;
    b.wk = wk; b.hk = hk; b.wh = wh; b.hh = hh;
    return b;
  endfunction

  function automatic int clampc(input int v);
    if (v < 0) return 0;
    if (v > 1792) return 1792;
    return v;
  endfunction

  function automatic box_t rand_box();
    box_t b;
    b.kx1 = $urandom_range(0, 1792);
    b.ky1 = $urandom_range(0, 1792);
    b.wk  = $urandom_range(0, 255);
    b.hk  = $urandom_range(0, 255);
    b.kx2 = b.kx1 + b.wk;
    b.ky2 = b.ky1 + b.hk;
    b.hx1 = clampc(b.kx1 + int'($urandom_range(0, 120)) - 60);
    b.hy1 = clampc(b.ky1 + int'($urandom_range(0, 120)) - 60);
    b.wh  = $urandom_range(0, 255);
    b.hh  = $urandom_range(0, 255);
    b.hx2 = b.hx1 + b.wh;
    b.hy2 = b.hy1 + b.hh;
    // Occasionally decouple w/h from the coordinates to reach saturation,
    // negative and zero unions.
    if ($urandom_range(0, 4) == 0) begin
      b.wk = $urandom_range(0, 20);
      b.hk = $urandom_range(0, 20);
      b.wh = $urandom_range(0, 20);
      b.hh = $urandom_range(0, 20);
    end
    return b;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!in_rst) begin
      if (valid_iou) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid cycle=%0d iou=0x%0h expected no pulse", cyc, iou);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (iou !== e.val) begin
            errors++;
            $display("FAIL iou_value cycle=%0d got=0x%0h expected=0x%0h", cyc, iou, e.val);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL valid_latency got_cycle=%0d expected_cycle=%0d", cyc, e.cyc);
          end
          last_iou = e.val;
        end
      end else begin
        checks++;
        if (iou !== last_iou) begin
          errors++;
          $display("FAIL iou_hold cycle=%0d got=0x%0h expected=0x%0h", cyc, iou, last_iou);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout cycle=%0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    box_t b, b2;
    int   lat;
    reset_N = 1'b0;
    start   = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checks++;
    if (valid_iou !== 1'b0 || iou !== '0) begin
      errors++;
      $display("FAIL reset_state valid=%0b iou=0x%0h expected valid=0 iou=0", valid_iou, iou);
    end
    @(negedge clk);
    @(negedge clk);
    reset_N = 1'b1;
    in_rst  = 1'b0;
    @(negedge clk);

    run(mk(0, 0, 10, 10, 0, 0, 10, 10, 10, 10, 10, 10));   // identical -> 0x3FFFFF
    run(mk(0, 0, 10, 10, 5, 0, 15, 10, 10, 10, 10, 10));   // 1398101
    run(mk(0, 0, 10, 10, 5, 5, 15, 15, 10, 10, 10, 10));   // 599186
    run(mk(0, 0, 10, 10, 20, 20, 30, 30, 10, 10, 10, 10)); // disjoint -> 0
    run(mk(0, 0, 10, 10, 10, 0, 20, 10, 10, 10, 10, 10));  // touching -> 0
    run(mk(0, 0, 10, 10, 0, 0, 10, 10, 0, 0, 0, 0));       // union 0 -> 0
    run(mk(0, 0, 10, 10, 0, 0, 10, 10, 2, 2, 2, 2));       // negative union -> sat

    // Start repeated while busy and in DONE, inputs changed after capture.
    issue(mk(0, 0, 10, 10, 5, 0, 15, 10, 10, 10, 10, 10), lat);
    repeat (4) @(negedge clk);
    apply(mk(100, 100, 200, 200, 150, 150, 160, 160, 100, 100, 10, 10));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    apply(mk(0, 0, 50, 50, 0, 0, 50, 50, 50, 50, 50, 50));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Random traffic, mostly back-to-back.
    for (int i = 0; i < 40; i++) begin
      b = rand_box();
      run(b);
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) @(negedge clk);
    end

    // Reset in cycle 10 of a computation: no pulse, iou cleared.
    b2 = mk(0, 0, 10, 10, 5, 5, 15, 15, 10, 10, 10, 10);
    issue(b2, lat);
    repeat (9) @(negedge clk);
    reset_N = 1'b0;
    in_rst  = 1'b1;
    sbq.delete();
    last_iou = '0;
    #1;
    checks++;
    if (valid_iou !== 1'b0 || iou !== '0) begin
      errors++;
      $display("FAIL mid_reset valid=%0b iou=0x%0h expected valid=0 iou=0", valid_iou, iou);
    end
    @(negedge clk);
    reset_N = 1'b1;
    in_rst  = 1'b0;
    repeat (30) @(negedge clk);
    run(b2);

    for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", sbq.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
